pilha_arbitro: RTL and testbench

Arbiter and sequencer for the processor's 16x16 hardware stack. It shares the stack between two requesters: the control unit (UC) and the ALU (ULA). It serialises push and pop operations and tracks occupancy. It rejects overflow and underflow before they reach the stack array, and it returns pop data to the requester that was granted. It sits between UC/ULA and the stack storage, and is the only block that drives the stack's write-enable, source-select and pop strobes.

---
 rtl/pilha_arbitro.sv | 192 +++++++++++++++++++
 tb/tb_pilha_arbitro.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pilha_arbitro.sv
// pilha_arbitro: arbiter and sequencer for the shared hardware stack.
//   Serialises UC and ULA push/pop requests with round-robin tie-break, tracks
//   occupancy, rejects overflow/underflow before they reach the stack array and
//   returns pop data to the granted requester. All outputs decode from registers.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   uc_req_i/uc_op_i/uc_data_i   UC request (op 1=push, 0=pop) and push data
//   ula_req_i/ula_op_i/ula_data_i ULA request; only ula_data_i[DATA_W-1:0] is pushed
//   *_gnt_o, *_done_o, *_err_o   per-requester grant, completion pulse, reject flag
//   rd_data_o                    last pop result, held until the next pop completes
//   stk_push_o/stk_sel_o/stk_din_o/stk_pop_o, stk_dout_i  stack array interface
//   count_o, full_o, empty_o     occupancy
// Optional: define PILHA_ARB_STATS_EN to add ovf_cnt_o/unf_cnt_o, saturating
//   counters of rejected pushes and rejected pops.
module pilha_arbitro #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uc_req_i,
  input  logic              uc_op_i,
  input  logic [DATA_W-1:0] uc_data_i,
  input  logic              ula_req_i,
  input  logic              ula_op_i,
  input  logic [31:0]       ula_data_i,
  output logic              uc_gnt_o,
  output logic              ula_gnt_o,
  output logic              uc_done_o,
  output logic              ula_done_o,
  output logic              uc_err_o,
  output logic              ula_err_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              stk_push_o,
  output logic              stk_sel_o,
  output logic [DATA_W-1:0] stk_din_o,
  output logic              stk_pop_o,
  input  logic [DATA_W-1:0] stk_dout_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
`ifdef PILHA_ARB_STATS_EN
  ,
  output logic [7:0]        ovf_cnt_o,
  output logic [7:0]        unf_cnt_o
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StPush,
    StPop,
    StPopWait,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 0 = UC, 1 = ULA
  logic                op_q, op_d;        // 1 = push, 0 = pop
  logic                err_q, err_d;
  logic                rr_q, rr_d;        // tie-break pointer: 0 = UC first
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full, empty;
  logic                sel_ula, sel_op;

  // Upper ULA result bits are intentionally dropped.
  logic unused_ula_hi;
  assign unused_ula_hi = ^ula_data_i[31:DATA_W];

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Exactly one requester wins; on a tie rr_q decides.
  assign sel_ula = ula_req_i && (!uc_req_i || rr_q);
  assign sel_op  = sel_ula ? ula_op_i : uc_op_i;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    err_d     = err_q;
    rr_d      = rr_q;
    data_d    = data_q;
    rd_data_d = rd_data_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (uc_req_i || ula_req_i) begin
          owner_d = sel_ula;
          op_d    = sel_op;
          data_d  = sel_ula ? ula_data_i[DATA_W-1:0] : uc_data_i;
          if ((sel_op && full) || (!sel_op && empty)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = sel_op ? StPush : StPop;
          end
        end
      end
      StPush: begin
        count_d = count_q + CNT_W'(1);
        state_d = StDone;
      end
      StPop: begin
        count_d = count_q - CNT_W'(1);
        state_d = StPopWait;
      end
      StPopWait: begin
        rd_data_d = stk_dout_i;
        state_d   = StDone;
      end
      StDone: begin
        rr_d    = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      rr_q      <= 1'b0;
      data_q    <= '0;
      rd_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      err_q     <= err_d;
      rr_q      <= rr_d;
      data_q    <= data_d;
      rd_data_q <= rd_data_d;
      count_q   <= count_d;
    end
  end

  // Moore outputs: everything below decodes only from registered state.
  logic busy, in_done;
  assign busy    = (state_q != StIdle);
  assign in_done = (state_q == StDone);

  assign uc_gnt_o   = busy && !owner_q;
  assign ula_gnt_o  = busy && owner_q;
  assign uc_done_o  = in_done && !owner_q;
  assign ula_done_o = in_done && owner_q;
  assign uc_err_o   = in_done && !owner_q && err_q;
  assign ula_err_o  = in_done && owner_q && err_q;
  assign rd_data_o  = rd_data_q;
  assign stk_push_o = (state_q == StPush);
  assign stk_pop_o  = (state_q == StPop);
  assign stk_sel_o  = owner_q;
  assign stk_din_o  = data_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;

`ifdef PILHA_ARB_STATS_EN
  logic [7:0] ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (in_done && err_q) begin
      if (op_q && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
      if (!op_q && (unf_q != 8'hFF)) unf_d = unf_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_cnt_o = ovf_q;
  assign unf_cnt_o = unf_q;
`endif

endmodule

// File: tb/tb_pilha_arbitro.sv
module tb_pilha_arbitro;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uc_req = 1'b0, uc_op = 1'b0;
  logic [15:0] uc_data = '0;
  logic        ula_req = 1'b0, ula_op = 1'b0;
  logic [31:0] ula_data = '0;
  logic        uc_gnt, ula_gnt, uc_done, ula_done, uc_err, ula_err;
  logic [15:0] rd_data;
  logic        stk_push, stk_sel, stk_pop;
  logic [15:0] stk_din;
  logic [15:0] stk_dout;
  logic [4:0]  count;
  logic        full, empty;
`ifdef PILHA_ARB_STATS_EN
  logic [7:0]  ovf_cnt, unf_cnt;
`endif

  always #5 clk = ~clk;

  pilha_arbitro dut (
    .clk        (clk),
    .rst        (rst),
    .uc_req_i   (uc_req),
    .uc_op_i    (uc_op),
    .uc_data_i  (uc_data),
    .ula_req_i  (ula_req),
    .ula_op_i   (ula_op),
    .ula_data_i (ula_data),
    .uc_gnt_o   (uc_gnt),
    .ula_gnt_o  (ula_gnt),
    .uc_done_o  (uc_done),
    .ula_done_o (ula_done),
    .uc_err_o   (uc_err),
    .ula_err_o  (ula_err),
    .rd_data_o  (rd_data),
    .stk_push_o (stk_push),
    .stk_sel_o  (stk_sel),
    .stk_din_o  (stk_din),
    .stk_pop_o  (stk_pop),
    .stk_dout_i (stk_dout),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
`ifdef PILHA_ARB_STATS_EN
    ,
    .ovf_cnt_o  (ovf_cnt),
    .unf_cnt_o  (unf_cnt)
`endif
  );

  // Stack storage model: write on stk_push, read data valid the cycle after stk_pop.
  logic [15:0] mem [16];
  logic [4:0]  sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= '0;
      stk_dout <= '0;
    end else if (stk_push && sp < 5'd16) begin
      mem[sp[3:0]] <= stk_din;
      sp           <= sp + 5'd1;
    end else if (stk_pop && sp > 5'd0) begin
      stk_dout <= mem[4'(sp - 5'd1)];
      sp       <= sp - 5'd1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ula;
    bit          err;
    int          lat;
    int          t0;
    int          npush;
    int          npop;
    logic [15:0] din;
    logic [15:0] rd;
    logic [4:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_stk[$];
  int          model_cnt = 0;
  logic [15:0] model_rd = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive one request and push its expected outcome; extra = cycles spent waiting behind
  // another requester before acceptance.
  task automatic issue(input bit ula, input bit op, input logic [31:0] data, input int extra);
    exp_t e;
    e.ula = ula;
    e.t0  = cyc;
    e.din = data[15:0];
    e.err = op ? (model_cnt == 16) : (model_cnt == 0);
    e.npush = 0;
    e.npop  = 0;
    if (e.err) e.lat = 1 + extra;
    else if (op) begin
      e.lat = 2 + extra;
      e.npush = 1;
      model_stk.push_back(data[15:0]);
      model_cnt++;
    end else begin
      e.lat = 3 + extra;
      e.npop = 1;
      model_rd = model_stk.pop_back();
      model_cnt--;
    end
    e.rd  = model_rd;
    e.cnt = 5'(model_cnt);
    sb.push_back(e);
    if (ula) begin
      ula_req = 1'b1; ula_op = op; ula_data = data;
    end else begin
      uc_req = 1'b1; uc_op = op; uc_data = data[15:0];
    end
  endtask

  task automatic wait_done(input int n);
    int seen = 0;
    int pushes = 0;
    int pops = 0;
    exp_t e;
    for (int k = 0; k < 60 && seen < n; k++) begin
      @(negedge clk);
      if (uc_gnt) uc_req = 1'b0;
      if (ula_gnt) ula_req = 1'b0;
      if (stk_push) begin
        pushes++;
        if (sb.size() > 0) begin
          check("push_sel", 32'(stk_sel), 32'(sb[0].ula));
          check("push_din", 32'(stk_din), 32'(sb[0].din));
        end
      end
      if (stk_pop) pops++;
      if (uc_done || ula_done) begin
        checks++;
        assert (sb.size() > 0) else begin
          failures++;
          $error("FAIL unexpected_done got=%0d want=0 pending", sb.size());
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("done_owner", {30'd0, uc_done, ula_done}, {30'd0, ~e.ula, e.ula});
          check("gnt_owner", {30'd0, uc_gnt, ula_gnt}, {30'd0, ~e.ula, e.ula});
          check("err", {30'd0, uc_err, ula_err}, e.err ? {30'd0, ~e.ula, e.ula} : 32'd0);
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
          check("count", 32'(count), 32'(e.cnt));
          check("rd_data", 32'(rd_data), 32'(e.rd));
          check("n_push", 32'(pushes), 32'(e.npush));
          check("n_pop", 32'(pops), 32'(e.npop));
        end
        pushes = 0;
        pops = 0;
        seen++;
      end
    end
    check("done_timeout", 32'(seen), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uc_req = 1'b0;
    ula_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    model_stk.delete();
    model_cnt = 0;
    model_rd = '0;
  endtask

  initial begin
    int done_seen;
    // 1: reset state
    do_reset();
    @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    check("rst_outs", {22'd0, uc_gnt, ula_gnt, uc_done, ula_done, uc_err, ula_err,
                       stk_push, stk_pop, stk_sel, 1'b0}, 32'd0);
`ifdef PILHA_ARB_STATS_EN
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    check("rst_unf", 32'(unf_cnt), 32'd0);
`endif

    // 2: lone UC push
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 32'h1234, 0);
    wait_done(1);

    // 3: simultaneous pushes after reset, UC wins the first tie
    do_reset();
    issue(1'b0, 1'b1, 32'h00AA, 0);
    issue(1'b1, 1'b1, 32'h0001ABCD, 3);
    wait_done(2);

    // 4: ULA pop on empty stack
    do_reset();
    issue(1'b1, 1'b0, 32'h0, 0);
    wait_done(1);
`ifdef PILHA_ARB_STATS_EN
    check("unf_cnt", 32'(unf_cnt), 32'd1);
`endif

    // 5: fill, overflow, then pop the top entry
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      issue(1'b0, 1'b1, 32'(i), 0);
      wait_done(1);
    end
    check("full_after_16", 32'(full), 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 1'b1, 32'h0BAD, 0);
    wait_done(1);
`ifdef PILHA_ARB_STATS_EN
    check("ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 32'h0, 0);
    wait_done(1);
    check("pop_top", 32'(rd_data), 32'd15);

    // 6: reset in POP_WAIT aborts the pop
    @(posedge clk); #1;
    uc_op = 1'b0;
    uc_req = 1'b1;
    @(posedge clk); #1;
    uc_req = 1'b0;
    check("abort_pop_strobe", 32'(stk_pop), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_count", 32'(count), 32'd0);
    check("abort_stk_pop", 32'(stk_pop), 32'd0);
    check("abort_gnt", {30'd0, uc_gnt, ula_gnt}, 32'd0);
    check("abort_empty", 32'(empty), 32'd1);
    do_reset();
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (uc_done || ula_done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
